// File: rtl/shake128_sponge_ctrl.sv
// SHAKE128 sponge sequencer around an external 24-round Keccak-f[1600] core.
// Optional feature: define SHAKE_PERM_CNT_EN to add the perm_count output.
module shake128_sponge_ctrl #(
    parameter int unsigned RATE_LANES = 21,
    parameter logic [7:0]  DOMAIN_PAD = 8'h1F
`ifdef SHAKE_PERM_CNT_EN
    ,
    parameter int unsigned CNT_W      = 16
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic          in_last,
    input  logic [3:0]    in_bytes,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_data,
    output logic          busy,
`ifdef SHAKE_PERM_CNT_EN
    output logic [CNT_W-1:0] perm_count,
`endif
    output logic          perm_enable,
    output logic [1599:0] perm_in,
    input  logic [1599:0] perm_state_out,
    input  logic          perm_valid
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ABSORB  = 3'd1;
    localparam logic [2:0] ST_PERM    = 3'd2;
    localparam logic [2:0] ST_GAP     = 3'd3;
    localparam logic [2:0] ST_SQUEEZE = 3'd4;

    localparam int unsigned LIDX_W     = $clog2(RATE_LANES);
    localparam int unsigned RATE_BYTES = 8 * RATE_LANES;
    localparam int unsigned END_BIT    = 8 * (RATE_BYTES - 1);
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(RATE_LANES - 1);

    logic [2:0]        state_q, state_d;
    logic              next_sq_q, next_sq_d;
    logic [1599:0]     s_q, s_d;
    logic [LIDX_W-1:0] lane_idx_q, lane_idx_d;
    logic [LIDX_W-1:0] sq_idx_q, sq_idx_d;
    logic              pad_pending_q, pad_pending_d;

    logic [3:0]        n_bytes_s;
    logic [63:0]       lane_mask_s;
    logic [63:0]       lane_in_s;
    logic [7:0]        pad_pos_s;
    logic [10:0]       lane_base_s;
    logic [10:0]       pad_base_s;
    logic [10:0]       sq_base_s;

    // Byte mask, pad position and bit offsets for the lane currently offered.
    always_comb begin
        n_bytes_s   = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        lane_mask_s = '0;
        for (int b = 0; b < 8; b++) begin
            if (in_last && (b >= int'(n_bytes_s))) begin
                lane_mask_s[8*b +: 8] = 8'h00;
            end else begin
                lane_mask_s[8*b +: 8] = 8'hFF;
            end
        end
        lane_in_s   = in_data & lane_mask_s;
        pad_pos_s   = 8'(lane_idx_q) * 8'd8 + 8'(n_bytes_s);
        lane_base_s = 11'(lane_idx_q) * 11'd64;
        pad_base_s  = 11'(pad_pos_s) * 11'd8;
        sq_base_s   = 11'(sq_idx_q) * 11'd64;
    end

    // Sponge FSM: absorb, pad, permute and squeeze; stop overrides everything.
    always_comb begin
        state_d       = state_q;
        next_sq_d     = next_sq_q;
        s_d           = s_q;
        lane_idx_d    = lane_idx_q;
        sq_idx_d      = sq_idx_q;
        pad_pending_d = pad_pending_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d           = '0;
                    lane_idx_d    = '0;
                    pad_pending_d = 1'b0;
                    state_d       = ST_ABSORB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABSORB: begin
                if (in_valid) begin
                    s_d[lane_base_s +: 64] = s_q[lane_base_s +: 64] ^ lane_in_s;
                    if (!in_last) begin
                        if (lane_idx_q == LAST_LANE) begin
                            lane_idx_d = '0;
                            next_sq_d  = 1'b0;
                            state_d    = ST_PERM;
                        end else begin
                            lane_idx_d = lane_idx_q + LIDX_W'(1);
                        end
                    end else begin
                        // A message filling the block exactly needs a whole extra pad block.
                        if (pad_pos_s < 8'(RATE_BYTES)) begin
                            s_d[pad_base_s +: 8] = s_d[pad_base_s +: 8] ^ DOMAIN_PAD;
                            s_d[END_BIT +: 8]    = s_d[END_BIT +: 8] ^ 8'h80;
                        end else begin
                            pad_pending_d = 1'b1;
                        end
                        lane_idx_d = '0;
                        next_sq_d  = 1'b1;
                        state_d    = ST_PERM;
                    end
                end else begin
                    state_d = ST_ABSORB;
                end
            end
            ST_PERM: begin
                if (perm_valid) begin
                    s_d     = perm_state_out;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_PERM;
                end
            end
            ST_GAP: begin
                lane_idx_d = '0;
                sq_idx_d   = '0;
                if (pad_pending_q) begin
                    s_d[7:0]          = s_q[7:0] ^ DOMAIN_PAD;
                    s_d[END_BIT +: 8] = s_q[END_BIT +: 8] ^ 8'h80;
                    pad_pending_d     = 1'b0;
                    next_sq_d         = 1'b1;
                    state_d           = ST_PERM;
                end else if (next_sq_q) begin
                    state_d = ST_SQUEEZE;
                end else begin
                    state_d = ST_ABSORB;
                end
            end
            ST_SQUEEZE: begin
                if (out_ready) begin
                    if (sq_idx_q == LAST_LANE) begin
                        sq_idx_d  = '0;
                        next_sq_d = 1'b1;
                        state_d   = ST_PERM;
                    end else begin
                        sq_idx_d = sq_idx_q + LIDX_W'(1);
                    end
                end else begin
                    state_d = ST_SQUEEZE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (stop) begin
            state_d       = ST_IDLE;
            next_sq_d     = next_sq_q;
            s_d           = s_q;
            lane_idx_d    = lane_idx_q;
            sq_idx_d      = sq_idx_q;
            pad_pending_d = pad_pending_q;
        end else begin
            state_d = state_d;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            next_sq_q     <= 1'b0;
            s_q           <= '0;
            lane_idx_q    <= '0;
            sq_idx_q      <= '0;
            pad_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            next_sq_q     <= next_sq_d;
            s_q           <= s_d;
            lane_idx_q    <= lane_idx_d;
            sq_idx_q      <= sq_idx_d;
            pad_pending_q <= pad_pending_d;
        end
    end

    assign in_ready    = (state_q == ST_ABSORB);
    assign out_valid   = (state_q == ST_SQUEEZE);
    assign perm_enable = (state_q == ST_PERM);
    assign busy        = (state_q != ST_IDLE);
    assign perm_in     = s_q;
    assign out_data    = s_q[sq_base_s +: 64];

`ifdef SHAKE_PERM_CNT_EN
    logic [CNT_W-1:0] perm_count_q, perm_count_d;

    // Permutations finished since the last accepted start, saturating.
    always_comb begin
        if ((state_q == ST_IDLE) && start && !stop) begin
            perm_count_d = '0;
        end else if ((state_q == ST_PERM) && perm_valid && !stop &&
                     (perm_count_q != {CNT_W{1'b1}})) begin
            perm_count_d = perm_count_q + CNT_W'(1);
        end else begin
            perm_count_d = perm_count_q;
        end
    end

    // Permutation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perm_count_q <= '0;
        end else begin
            perm_count_q <= perm_count_d;
        end
    end

    assign perm_count = perm_count_q;
`endif

endmodule
